// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and address helpers for the multi-port register file.
package regfile_mp_sb_pkg;

  localparam int RF_DW       = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_AW       = $clog2(RF_DEPTH);
  localparam int RF_ZERO_IDX = 0;

  // Enabled access whose address matches another address
  function automatic logic rf_hit(input logic [31:0] addr_a,
                                  input logic [31:0] addr_b,
                                  input logic        en);
    return en && (addr_a == addr_b);
  endfunction

  // Address names a real, writable register (in range, not the hardwired zero)
  function automatic logic rf_addr_ok(input int addr, input int depth, input int zero_reg);
    return (addr < depth) && !((zero_reg != 0) && (addr == RF_ZERO_IDX));
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read/write/issue bus of the register file. Fields are flat vectors, port n
// occupies slice [n*W +: W].
interface regfile_mp_sb_if
  import regfile_mp_sb_pkg::*;
#(
  parameter int DW     = RF_DW,
  parameter int AW     = RF_AW,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
                  input  rd_data, rd_busy);
  modport slave  (input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
                  output rd_data, rd_busy);
endinterface

// File: rtl/regfile_mp_sb_rd_port.sv
// One combinational read port: write-first bypass mux and busy masking.
module regfile_mp_sb_rd_port
  import regfile_mp_sb_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 rst_n,
  input  logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        st_data,
  input  logic                 st_busy,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_busy
);

  logic          byp_hit;
  logic [DW-1:0] byp_data;

  // Find the highest-index write port hitting this address (later ports override)
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (rf_hit(32'(rd_addr), 32'(wr_addr[w*AW +: AW]), wr_en[w])) begin
        byp_hit  = 1'b1;
        byp_data = wr_data[w*DW +: DW];
      end
    end
  end

  // Stored value, overridden by bypass, then forced to zero for reset / zero reg / out of range
  always_comb begin
    rd_data = st_data;
    rd_busy = st_busy;
    if ((BYPASS != 0) && byp_hit) begin
      rd_data = byp_data;
      rd_busy = 1'b0;
    end
    if (!rst_n || !rf_addr_ok(int'(rd_addr), DEPTH, ZERO_REG)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register pending-write scoreboard.
// Owns storage, busy vector and write decode; read ports are sub-instances.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_sb_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  // Storage is sized to the full address space so any address indexes safely;
  // entries at or above DEPTH are never written and read as zero.
  localparam int NREG = 1 << AW;

  logic [NREG-1:0][DW-1:0] mem_q, mem_d;
  logic [NREG-1:0]         busy_q, busy_d;
  logic [AW-1:0]           wa;

  // Write decode in ascending port order so the highest port wins; issue sets
  // busy after writeback clears it, so a same-cycle re-issue keeps it pending
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    wa     = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa = bus.wr_addr[w*AW +: AW];
      if (bus.wr_en[w] && rf_addr_ok(int'(wa), DEPTH, ZERO_REG)) begin
        mem_d[wa]  = bus.wr_data[w*DW +: DW];
        busy_d[wa] = 1'b0;
      end
    end
    if (bus.iss_en && rf_addr_ok(int'(bus.iss_addr), DEPTH, ZERO_REG))
      busy_d[bus.iss_addr] = 1'b1;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0] rd_a;
    assign rd_a = bus.rd_addr[r*AW +: AW];

    regfile_mp_sb_rd_port #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .NUM_WR(NUM_WR),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .rst_n   (rst_n),
      .rd_addr (rd_a),
      .st_data (mem_q[rd_a]),
      .st_busy (busy_q[rd_a]),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_data (bus.rd_data[r*DW +: DW]),
      .rd_busy (bus.rd_busy[r])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb. Two configurations side by side:
//   A: 3 read / 2 write ports, zero reg, bypass, depth 32
//   B: 2 read / 1 write port, no zero reg, no bypass, depth 24
module tb_regfile_mp_sb;
  localparam int AW      = 5;
  localparam int B_DEPTH = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp  = 0;
  int   nfail = 0;

  // Reference state: register contents and pending flags
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          ba [32];
  bit          bb [32];

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DW(32), .AW(AW), .NUM_RD(3), .NUM_WR(2)) ia ();
  regfile_mp_sb_if #(.DW(32), .AW(AW), .NUM_RD(2), .NUM_WR(1)) ib ();

  regfile_mp_sb #(.DW(32), .DEPTH(32), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
    ua (.clk(clk), .rst_n(rst_n), .bus(ia));
  regfile_mp_sb #(.DW(32), .DEPTH(B_DEPTH), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0))
    ub (.clk(clk), .rst_n(rst_n), .bus(ib));

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ia.wr_en = '0; ia.iss_en = 1'b0;
    ib.wr_en = '0; ib.iss_en = 1'b0;
  endtask

  task automatic a_wr(input int w, input int a, input logic [31:0] d);
    ia.wr_en[w] = 1'b1; ia.wr_addr[w*AW +: AW] = 5'(a); ia.wr_data[w*32 +: 32] = d;
  endtask

  task automatic b_wr(input int a, input logic [31:0] d);
    ib.wr_en[0] = 1'b1; ib.wr_addr = 5'(a); ib.wr_data = d;
  endtask

  task automatic a_rd(input int r, input int a);
    ia.rd_addr[r*AW +: AW] = 5'(a);
  endtask

  task automatic b_rd(input int r, input int a);
    ib.rd_addr[r*AW +: AW] = 5'(a);
  endtask

  task automatic clr_model();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0; mb[i] = '0; ba[i] = 1'b0; bb[i] = 1'b0;
    end
  endtask

  // ---------------- reference model ----------------
  // A: reg 0 is constant zero; a same-cycle write (last port wins) is visible
  function automatic logic [31:0] a_exp(input int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = ma[a];
    for (int w = 0; w < 2; w++)
      if (ia.wr_en[w] && int'(ia.wr_addr[w*AW +: AW]) == a) v = ia.wr_data[w*32 +: 32];
    return v;
  endfunction

  function automatic bit a_bsy(input int a);
    if (a == 0) return 1'b0;
    for (int w = 0; w < 2; w++)
      if (ia.wr_en[w] && int'(ia.wr_addr[w*AW +: AW]) == a) return 1'b0;
    return ba[a];
  endfunction

  // B: plain stored value, zero outside the implemented range
  function automatic logic [31:0] b_exp(input int a);
    return (a < B_DEPTH) ? mb[a] : 32'h0;
  endfunction

  function automatic bit b_bsy(input int a);
    return (a < B_DEPTH) ? bb[a] : 1'b0;
  endfunction

  // Apply this cycle's writes and issue to the model as the clock edge would
  task automatic commit();
    int a;
    for (int w = 0; w < 2; w++) begin
      if (ia.wr_en[w]) begin
        a = int'(ia.wr_addr[w*AW +: AW]);
        if (a != 0) begin ma[a] = ia.wr_data[w*32 +: 32]; ba[a] = 1'b0; end
      end
    end
    if (ia.iss_en && ia.iss_addr != 0) ba[int'(ia.iss_addr)] = 1'b1;
    if (ib.wr_en[0]) begin
      a = int'(ib.wr_addr);
      if (a < B_DEPTH) begin mb[a] = ib.wr_data; bb[a] = 1'b0; end
    end
    if (ib.iss_en && int'(ib.iss_addr) < B_DEPTH) bb[int'(ib.iss_addr)] = 1'b1;
  endtask

  task automatic tick();
    if (rst_n) commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ia.rd_addr = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.iss_addr = '0;
    ib.rd_addr = '0; ib.wr_addr = '0; ib.wr_data = '0; ib.iss_addr = '0;
    idle(); clr_model();
    a_rd(0, 5); b_rd(0, 5);
    #2;
    if (ia.rd_data[31:0] !== 32'h0 || ia.rd_busy !== 3'b000) begin
      $display("FAIL reset_hold_a data=%h busy=%b exp 0/000", ia.rd_data[31:0], ia.rd_busy); nfail++;
    end
    ncmp++;
    @(negedge clk); rst_n = 1'b1;
    tick();
    a_wr(0, 5, 32'hDEAD_BEEF); ia.iss_en = 1'b1; ia.iss_addr = 5'd5;
    b_wr(5, 32'hDEAD_BEEF);    ib.iss_en = 1'b1; ib.iss_addr = 5'd5;
    tick(); idle(); #1;
    if (ia.rd_data[31:0] !== 32'hDEAD_BEEF || ia.rd_busy[0] !== 1'b1) begin
      $display("FAIL reset_pre_a data=%h busy=%b exp deadbeef/1", ia.rd_data[31:0], ia.rd_busy[0]); nfail++;
    end
    ncmp++;
    // mid-cycle reset, with a write in flight that must be lost
    a_wr(0, 5, 32'h5555_5555); b_wr(5, 32'h5555_5555);
    #1 rst_n = 1'b0;
    #1;
    if (ia.rd_data[31:0] !== 32'h0 || ia.rd_busy[0] !== 1'b0) begin
      $display("FAIL reset_async_a data=%h busy=%b exp 0/0", ia.rd_data[31:0], ia.rd_busy[0]); nfail++;
    end
    ncmp++;
    if (ib.rd_data[31:0] !== 32'h0 || ib.rd_busy[0] !== 1'b0) begin
      $display("FAIL reset_async_b data=%h busy=%b exp 0/0", ib.rd_data[31:0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
    clr_model();
    @(posedge clk); #1;
    idle();
    @(negedge clk); rst_n = 1'b1;
    #1;
    if (ia.rd_data[31:0] !== 32'h0 || ib.rd_data[31:0] !== 32'h0) begin
      $display("FAIL reset_lost_wr a=%h b=%h exp 0/0", ia.rd_data[31:0], ib.rd_data[31:0]); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_zero_reg();
    idle();
    a_wr(0, 0, 32'h1234); ia.iss_en = 1'b1; ia.iss_addr = 5'd0;
    b_wr(0, 32'h1234);    ib.iss_en = 1'b1; ib.iss_addr = 5'd0;
    for (int r = 0; r < 3; r++) a_rd(r, 0);
    b_rd(0, 0); b_rd(1, 0);
    #1;
    if (ia.rd_data[31:0] !== 32'h0 || ia.rd_busy[0] !== 1'b0) begin
      $display("FAIL zero_byp_a data=%h busy=%b exp 0/0", ia.rd_data[31:0], ia.rd_busy[0]); nfail++;
    end
    ncmp++;
    tick(); idle(); #1;
    if (ia.rd_data !== 96'h0 || ia.rd_busy !== 3'b000) begin
      $display("FAIL zero_reg_a data=%h busy=%b exp 0/000", ia.rd_data, ia.rd_busy); nfail++;
    end
    ncmp++;
    if (ib.rd_data[31:0] !== 32'h1234 || ib.rd_busy[0] !== 1'b1) begin
      $display("FAIL zero_reg_b data=%h busy=%b exp 1234/1", ib.rd_data[31:0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_bypass();
    idle();
    a_wr(0, 7, 32'h1111); b_wr(7, 32'h1111);
    tick(); idle();
    a_wr(0, 7, 32'hA5A5_0001); b_wr(7, 32'hA5A5_0001);
    a_rd(0, 7); b_rd(0, 7);
    #1;
    if (ia.rd_data[31:0] !== 32'hA5A5_0001) begin
      $display("FAIL bypass_a got=%h exp=a5a50001", ia.rd_data[31:0]); nfail++;
    end
    ncmp++;
    if (ib.rd_data[31:0] !== 32'h1111) begin
      $display("FAIL nobypass_b_old got=%h exp=00001111", ib.rd_data[31:0]); nfail++;
    end
    ncmp++;
    tick(); idle(); #1;
    if (ib.rd_data[31:0] !== 32'hA5A5_0001) begin
      $display("FAIL nobypass_b_new got=%h exp=a5a50001", ib.rd_data[31:0]); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_wr_conflict();
    idle();
    a_wr(0, 3, 32'h11); a_wr(1, 3, 32'h22); a_rd(0, 3);
    #1;
    if (ia.rd_data[31:0] !== 32'h22) begin
      $display("FAIL conflict_byp got=%h exp=22", ia.rd_data[31:0]); nfail++;
    end
    ncmp++;
    tick(); idle(); #1;
    if (ia.rd_data[31:0] !== 32'h22) begin
      $display("FAIL conflict_store got=%h exp=22", ia.rd_data[31:0]); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_scoreboard();
    idle();
    ia.iss_en = 1'b1; ia.iss_addr = 5'd9; ib.iss_en = 1'b1; ib.iss_addr = 5'd9;
    a_rd(0, 9); b_rd(0, 9);
    #1;
    if (ia.rd_busy[0] !== 1'b0 || ib.rd_busy[0] !== 1'b0) begin
      $display("FAIL sb_pre a=%b b=%b exp 0/0", ia.rd_busy[0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
    tick(); idle(); #1;
    if (ia.rd_busy[0] !== 1'b1 || ib.rd_busy[0] !== 1'b1) begin
      $display("FAIL sb_issue a=%b b=%b exp 1/1", ia.rd_busy[0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
    a_wr(0, 9, 32'h99); b_wr(9, 32'h99);
    ia.iss_en = 1'b1; ia.iss_addr = 5'd9; ib.iss_en = 1'b1; ib.iss_addr = 5'd9;
    #1;
    if (ia.rd_busy[0] !== 1'b0 || ib.rd_busy[0] !== 1'b1) begin
      $display("FAIL sb_wb_iss_comb a=%b b=%b exp 0/1", ia.rd_busy[0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
    tick(); idle(); #1;
    if (ia.rd_busy[0] !== 1'b1 || ib.rd_busy[0] !== 1'b1) begin
      $display("FAIL sb_reissue a=%b b=%b exp 1/1", ia.rd_busy[0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
    a_wr(0, 9, 32'h9A); b_wr(9, 32'h9A);
    tick(); idle(); #1;
    if (ia.rd_busy[0] !== 1'b0 || ib.rd_busy[0] !== 1'b0) begin
      $display("FAIL sb_wb_clear a=%b b=%b exp 0/0", ia.rd_busy[0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_multi_read();
    idle();
    a_wr(0, 1, 32'h0101); a_wr(1, 2, 32'h0202); ia.iss_en = 1'b1; ia.iss_addr = 5'd1;
    tick(); idle();
    ia.iss_en = 1'b1; ia.iss_addr = 5'd2;
    tick(); idle();
    a_wr(1, 2, 32'h2222); a_rd(0, 1); a_rd(1, 2); a_rd(2, 1);
    #1;
    if (ia.rd_data !== {32'h0101, 32'h2222, 32'h0101} || ia.rd_busy !== 3'b101) begin
      $display("FAIL multi_rd_comb data=%h busy=%b exp 00000101_00002222_00000101/101",
               ia.rd_data, ia.rd_busy); nfail++;
    end
    ncmp++;
    tick(); idle(); #1;
    if (ia.rd_data !== {32'h0101, 32'h2222, 32'h0101} || ia.rd_busy !== 3'b101) begin
      $display("FAIL multi_rd_after data=%h busy=%b exp 00000101_00002222_00000101/101",
               ia.rd_data, ia.rd_busy); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_out_of_range();
    idle();
    b_wr(25, 32'hFFFF); ib.iss_en = 1'b1; ib.iss_addr = 5'd25;
    b_rd(0, 25);
    tick(); idle(); #1;
    if (ib.rd_data[31:0] !== 32'h0 || ib.rd_busy[0] !== 1'b0) begin
      $display("FAIL oor_b data=%h busy=%b exp 0/0", ib.rd_data[31:0], ib.rd_busy[0]); nfail++;
    end
    ncmp++;
    b_wr(23, 32'hCAFE); b_rd(1, 23);
    tick(); idle(); #1;
    if (ib.rd_data[63:32] !== 32'hCAFE) begin
      $display("FAIL top_reg_b got=%h exp=0000cafe", ib.rd_data[63:32]); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int w = 0; w < 2; w++)
        if ($urandom_range(0, 1) == 1) a_wr(w, (n % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
      ia.iss_en = 1'($urandom_range(0, 1)); ia.iss_addr = 5'($urandom_range(0, 7));
      for (int r = 0; r < 3; r++) a_rd(r, $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) b_wr($urandom_range(0, 31), $urandom);
      ib.iss_en = 1'($urandom_range(0, 1)); ib.iss_addr = 5'($urandom_range(0, 31));
      for (int r = 0; r < 2; r++) b_rd(r, $urandom_range(0, 31));
      #1;
      for (int r = 0; r < 3; r++) begin
        int ad;
        ad = int'(ia.rd_addr[r*AW +: AW]);
        if (ia.rd_data[r*32 +: 32] !== a_exp(ad) || ia.rd_busy[r] !== 1'(a_bsy(ad))) begin
          $display("FAIL rnd_a cyc%0d port%0d addr%0d got=%h/%b exp=%h/%b", n, r, ad,
                   ia.rd_data[r*32 +: 32], ia.rd_busy[r], a_exp(ad), a_bsy(ad)); nfail++;
        end
        ncmp++;
      end
      for (int r = 0; r < 2; r++) begin
        int ad;
        ad = int'(ib.rd_addr[r*AW +: AW]);
        if (ib.rd_data[r*32 +: 32] !== b_exp(ad) || ib.rd_busy[r] !== 1'(b_bsy(ad))) begin
          $display("FAIL rnd_b cyc%0d port%0d addr%0d got=%h/%b exp=%h/%b", n, r, ad,
                   ib.rd_data[r*32 +: 32], ib.rd_busy[r], b_exp(ad), b_bsy(ad)); nfail++;
        end
        ncmp++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_wr_conflict();
    test_scoreboard();
    test_multi_read();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
